bcd_string_seq: RTL

- Multi-cycle sequencer for the packed-BCD string instructions ADD4S, SUB4S and CMP4S.
- Steps through byte pairs at source offset IX and destination offset IY over a simple byte memory handshake.
- Drives the shared combinational ALU in byte mode: ADDC/SUBC, then ADJ4A/ADJ4S.
- Writes results back and returns the final CY and Z to the execution unit.

---
 rtl/bcd_string_seq_pkg.sv | 24 ++
 rtl/bcd_string_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_string_seq_pkg.sv
// Shared types for the packed-BCD string sequencer and the byte ALU it drives.
//   alu_operation_e : ALU operation select
//   flags_t         : ALU flag bundle (only cy and ac are used by the sequencer)
package bcd_string_seq_pkg;

  typedef enum logic [2:0] {
    ALU_OP_ADD,
    ALU_OP_ADDC,
    ALU_OP_SUB,
    ALU_OP_SUBC,
    ALU_OP_ADJ4A,
    ALU_OP_ADJ4S
  } alu_operation_e;

  typedef struct packed {
    logic of;
    logic sf;
    logic zf;
    logic ac;
    logic pf;
    logic cy;
  } flags_t;

endpackage

// File: rtl/bcd_string_seq.sv
// Multi-cycle sequencer for ADD4S / SUB4S / CMP4S over packed-BCD byte strings.
// Reads source byte at ix+i and destination byte at iy+i, runs ADDC/SUBC followed by
// ADJ4A/ADJ4S on the shared ALU, writes the result back (except CMP4S) and reports CY/Z.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, op, ix, iy, cl   launch pulse, operation, source/destination offsets, digit count
//   busy, done, cy_out, z_out   status and final flags
//   mem_*               registered byte memory handshake (req/ack)
//   alu_*               byte-mode drive of the external combinational ALU
module bcd_string_seq
  import bcd_string_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] ix,
  input  logic [ADDR_W-1:0] iy,
  input  logic [7:0]        cl,
  output logic              busy,
  output logic              done,
  output logic              cy_out,
  output logic              z_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output alu_operation_e    alu_op,
  output logic [15:0]       alu_ta,
  output logic [15:0]       alu_tb,
  output logic              alu_wide,
  output flags_t            alu_flags_in,
  input  logic [15:0]       alu_result,
  input  flags_t            alu_flags
);

  typedef enum logic [2:0] {
    StIdle, StRdSrc, StRdDst, StArith, StAdj, StWr, StNext, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] ix_q, ix_d, iy_q, iy_d;
  logic [8:0]        nbytes_q, nbytes_d, idx_q, idx_d;
  logic [7:0]        sbyte_q, sbyte_d, dbyte_q, dbyte_d, tmp_q, tmp_d, rbyte_q, rbyte_d;
  logic              carry_q, carry_d, ac_q, ac_d, zacc_q, zacc_d;
  logic              done_q, done_d, cy_out_q, cy_out_d, z_out_q, z_out_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              is_add, is_cmp;
  logic              unused_alu;

  assign is_add = (op_q == 2'd0);
  assign is_cmp = op_q[1];  // op 2 and reserved op 3 both compare only

  // Upper result byte and the remaining flags are irrelevant in byte mode.
  assign unused_alu = ^{alu_result[15:8], alu_flags};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= 2'd0;
      ix_q        <= '0;
      iy_q        <= '0;
      nbytes_q    <= '0;
      idx_q       <= '0;
      sbyte_q     <= '0;
      dbyte_q     <= '0;
      tmp_q       <= '0;
      rbyte_q     <= '0;
      carry_q     <= 1'b0;
      ac_q        <= 1'b0;
      zacc_q      <= 1'b1;
      done_q      <= 1'b0;
      cy_out_q    <= 1'b0;
      z_out_q     <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ix_q        <= ix_d;
      iy_q        <= iy_d;
      nbytes_q    <= nbytes_d;
      idx_q       <= idx_d;
      sbyte_q     <= sbyte_d;
      dbyte_q     <= dbyte_d;
      tmp_q       <= tmp_d;
      rbyte_q     <= rbyte_d;
      carry_q     <= carry_d;
      ac_q        <= ac_d;
      zacc_q      <= zacc_d;
      done_q      <= done_d;
      cy_out_q    <= cy_out_d;
      z_out_q     <= z_out_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ix_d        = ix_q;
    iy_d        = iy_q;
    nbytes_d    = nbytes_q;
    idx_d       = idx_q;
    sbyte_d     = sbyte_q;
    dbyte_d     = dbyte_q;
    tmp_d       = tmp_q;
    rbyte_d     = rbyte_q;
    carry_d     = carry_q;
    ac_d        = ac_q;
    zacc_d      = zacc_q;
    done_d      = 1'b0;
    cy_out_d    = cy_out_q;
    z_out_d     = z_out_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d     = op;
          ix_d     = ix;
          iy_d     = iy;
          // An odd digit count still occupies a whole byte.
          nbytes_d = ({1'b0, cl} + 9'd1) >> 1;
          idx_d    = '0;
          carry_d  = 1'b0;
          ac_d     = 1'b0;
          zacc_d   = 1'b1;
          state_d  = (nbytes_d == 9'd0) ? StDone : StRdSrc;
        end
      end
      StRdSrc: begin
        if (mem_ack) begin
          sbyte_d = mem_rdata;
          state_d = StRdDst;
        end
      end
      StRdDst: begin
        if (mem_ack) begin
          dbyte_d = mem_rdata;
          state_d = StArith;
        end
      end
      StArith: begin
        tmp_d   = alu_result[7:0];
        carry_d = alu_flags.cy;
        ac_d    = alu_flags.ac;
        state_d = StAdj;
      end
      StAdj: begin
        rbyte_d = alu_result[7:0];
        carry_d = alu_flags.cy;
        zacc_d  = zacc_q & (alu_result[7:0] == 8'h00);
        state_d = is_cmp ? StNext : StWr;
      end
      StWr: begin
        if (mem_ack) state_d = StNext;
      end
      StNext: begin
        idx_d   = idx_q + 9'd1;
        state_d = (idx_d == nbytes_q) ? StDone : StRdSrc;
      end
      StDone: begin
        done_d   = 1'b1;
        cy_out_d = carry_q;
        z_out_d  = zacc_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Request signals are registered from the next state so a request is already on the
    // bus in the first cycle of RD_SRC/RD_DST/WR; a back-to-back request follows an ack.
    mem_req_d = (state_d inside {StRdSrc, StRdDst, StWr});
    mem_we_d  = (state_d == StWr);
    if (mem_req_d) begin
      mem_addr_d = ((state_d == StRdSrc) ? ix_d : iy_d) + ADDR_W'(idx_d);
    end
    if (state_d == StWr) mem_wdata_d = rbyte_d;
  end

  always_comb begin
    busy         = (state_q != StIdle);
    done         = done_q;
    cy_out       = cy_out_q;
    z_out        = z_out_q;
    mem_req      = mem_req_q;
    mem_we       = mem_we_q;
    mem_addr     = mem_addr_q;
    mem_wdata    = mem_wdata_q;
    alu_wide     = 1'b0;
    alu_op       = ALU_OP_ADD;
    alu_ta       = '0;
    alu_tb       = '0;
    alu_flags_in = '0;
    case (state_q)
      StArith: begin
        alu_op          = is_add ? ALU_OP_ADDC : ALU_OP_SUBC;
        alu_ta          = {8'h00, dbyte_q};
        alu_tb          = {8'h00, sbyte_q};
        alu_flags_in.cy = carry_q;
      end
      StAdj: begin
        alu_op          = is_add ? ALU_OP_ADJ4A : ALU_OP_ADJ4S;
        alu_ta          = {8'h00, tmp_q};
        alu_flags_in.cy = carry_q;
        alu_flags_in.ac = ac_q;
      end
      default: ;
    endcase
  end

endmodule
